aw_w_packer: RTL and testbench
==============================

# aw_w_packer

Serializes an AXI4 write-address (AW) channel and write-data (W) channel into the bus-internal 77-bit write-forward stream. Each burst is emitted as one command beat followed by AWLEN+1 data beats. The block sits at each master port directly upstream of the per-slave write forward filters, which decode the address from the command beat and track burst end via bit 0 of the data beats. The output is registered and sustains one beat per cycle.

## Interface
- No parameters.
- CLK  input  1  clock; all logic on rising edge.
- RESETn  input  1  asynchronous, active-low reset.
- AWADDR  input  36  burst address.
- AWID  input  4  transaction ID.
- AWLEN  input  8  beats minus one.
- AWSIZE  input  3  beat size.
- AWBURST  input  2  burst type.
- AWCACHE  input  4  cache attributes.
- AWPROT  input  3  protection attributes.
- AWQOS  input  4  QoS value.
- AWVALID  input  1  AW valid.
- AWREADY  output  1  AW ready.
- WDATA  input  64  write data.
- WSTRB  input  8  byte strobes.
- WLAST  input  1  last beat of burst.
- WVALID  input  1  W valid.
- WREADY  output  1  W ready.
- DATAo  output  77  stream beat.
- VALIDo  output  1  stream valid.
- READYo  input  1  stream ready.
- LEN_ERR  output  1  sticky WLAST/AWLEN mismatch flag; tied 0 when length check is compiled out.

## Operation
- Command beat layout: [76:69] AWLEN, [68:33] AWADDR, [32:29] AWID, [28:26] AWSIZE, [25:24] AWBURST, [23:20] AWCACHE, [19:17] AWPROT, [16:13] AWQOS, [12:0] zero. Bit 0 is always 0.
- Data beat layout: [76:73] zero, [72:9] WDATA, [8:1] WSTRB, [0] LAST.
- Output register: a single register holds DATAo/VALIDo.
  - out_free = !VALIDo | READYo.
  - On out_free with an accepted input, the register loads the new beat.
  - On out_free without an accepted input, VALIDo clears.
  - DATAo holds its value while VALIDo=1 and READYo=0.
- rdy_en: register cleared by reset, set on the first clock after reset deassertion.
- FSM states:
  - S_CMD (reset state): AWREADY = rdy_en & out_free; WREADY = 0. On AWVALID&AWREADY, load the command beat, set cnt = AWLEN, and go to S_DATA.
  - S_DATA: WREADY = out_free; AWREADY = 0. On WVALID&WREADY, load the data beat. If the beat is final, go to S_CMD; otherwise cnt decrements.
- Final beat and LAST bit: without the macro, final = WLAST and LAST = WLAST.
- AW is never accepted while a burst is still in progress. W beats presented in S_CMD stall.

## Timing
- Reset values: DATAo=0, VALIDo=0, AWREADY=0, WREADY=0, LEN_ERR=0, state S_CMD, cnt=0.
- Latency: an input handshake in cycle N gives VALIDo=1 with that beat in cycle N+1.
- Throughput: with READYo held at 1, one beat per cycle. A burst of L+1 beats occupies L+2 output cycles. The next AW can be accepted in the same cycle the final beat appears on DATAo.
- Backpressure: when READYo=0 and VALIDo=1, AWREADY and WREADY are 0 combinationally in that cycle.
- AWLEN=0: the command beat is followed by exactly one data beat with LAST=1.
- Reset mid-burst: all state clears immediately and the in-flight beat is dropped. Downstream stages are reset by the same RESETn.

## Configuration
- Macro: AW_W_PACKER_LEN_CHECK_EN.
- Defined:
  - final = (cnt==0), and LAST = final, independent of WLAST.
  - On any accepted W beat where WLAST != final, LEN_ERR sets to 1 and stays set until reset.
  - The output stream is always length-consistent with AWLEN.
- Undefined: WLAST is trusted for both final and LAST, cnt is unused, and LEN_ERR = 0.

## Test plan
- Reset release → AWREADY=0 in the first cycle, AWREADY=1 in the second, VALIDo=0 throughout.
- AWADDR=36'h123456780, AWLEN=3, four W beats, READYo=1 → 5 consecutive VALIDo cycles. DATAo[68:33]=36'h123456780 on the first beat. Bit 0 reads 0,0,0,0,1.
- AWLEN=0 burst immediately followed by another AWLEN=0 burst, READYo=1 → 4 beats with no bubble; DATAo[0] reads 0,1,0,1.
- READYo=0 for 3 cycles mid-burst → DATAo stable, WREADY=0, no beat lost or duplicated; the stream resumes on the cycle after READYo=1.
- WVALID asserted before AWVALID → WREADY=0 until the command beat is accepted; beat order is still command then data.
- With AW_W_PACKER_LEN_CHECK_EN: AWLEN=1 and WLAST=1 on beat 0 → LEN_ERR=1, DATAo[0]=0 for beat 0 and 1 for beat 1. Without the macro, the same stimulus gives DATAo[0]=1 on beat 0, the block returns to S_CMD, and LEN_ERR=0.

Source files
------------

// File: rtl/aw_w_packer.sv
// AXI4 AW/W to 77-bit write-forward stream packer: one command beat, then AWLEN+1 data beats.
// Define AW_W_PACKER_LEN_CHECK_EN to frame bursts by AWLEN and flag WLAST mismatches on LEN_ERR.
module aw_w_packer (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic [35:0] AWADDR,
   input  logic [3:0]  AWID,
   input  logic [7:0]  AWLEN,
   input  logic [2:0]  AWSIZE,
   input  logic [1:0]  AWBURST,
   input  logic [3:0]  AWCACHE,
   input  logic [2:0]  AWPROT,
   input  logic [3:0]  AWQOS,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [63:0] WDATA,
   input  logic [7:0]  WSTRB,
   input  logic        WLAST,
   input  logic        WVALID,
   output logic        WREADY,
   output logic [76:0] DATAo,
   output logic        VALIDo,
   input  logic        READYo,
   output logic        LEN_ERR
);

   typedef enum logic [0:0] {StCmd, StData} state_e;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        rdy_en_q;
   logic        out_valid_q, out_valid_d;
   logic [76:0] out_data_q, out_data_d;
   logic        len_err_q, len_err_d;

   logic        out_free;
   logic        aw_hs;
   logic        w_hs;
   logic        beat_final;
   logic        len_mismatch;
   logic [76:0] cmd_beat;
   logic [76:0] data_beat;

   // Output slot is reusable when empty or being drained this cycle.
   assign out_free = ~out_valid_q | READYo;

   assign AWREADY = (state_q == StCmd) & rdy_en_q & out_free;
   assign WREADY  = (state_q == StData) & out_free;
   assign aw_hs   = AWVALID & AWREADY;
   assign w_hs    = WVALID & WREADY;

`ifdef AW_W_PACKER_LEN_CHECK_EN
   assign beat_final   = (cnt_q == 8'd0);
   assign len_mismatch = (WLAST != beat_final);
`else
   assign beat_final   = WLAST;
   assign len_mismatch = 1'b0;
`endif

   assign cmd_beat  = {AWLEN, AWADDR, AWID, AWSIZE, AWBURST, AWCACHE, AWPROT, AWQOS, 13'd0};
   assign data_beat = {4'd0, WDATA, WSTRB, beat_final};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      len_err_d   = len_err_q;

      if (out_free) begin
         out_valid_d = aw_hs | w_hs;
      end

      if (aw_hs) begin
         out_data_d = cmd_beat;
         cnt_d      = AWLEN;
         state_d    = StData;
      end else if (w_hs) begin
         out_data_d = data_beat;
         if (len_mismatch) begin
            len_err_d = 1'b1;
         end
         if (beat_final) begin
            state_d = StCmd;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q     <= StCmd;
         cnt_q       <= 8'd0;
         rdy_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 77'd0;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rdy_en_q    <= 1'b1;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         len_err_q   <= len_err_d;
      end
   end

   assign DATAo   = out_data_q;
   assign VALIDo  = out_valid_q;
   assign LEN_ERR = len_err_q;

endmodule

// File: tb/tb_aw_w_packer.sv
// Directed, table-driven bench for aw_w_packer; honours AW_W_PACKER_LEN_CHECK_EN if defined.
module tb_aw_w_packer;

   logic        CLK = 1'b0;
   logic        RESETn = 1'b0;
   logic [35:0] AWADDR = '0;
   logic [3:0]  AWID = '0;
   logic [7:0]  AWLEN = '0;
   logic [2:0]  AWSIZE = 3'd3;
   logic [1:0]  AWBURST = 2'd1;
   logic [3:0]  AWCACHE = 4'hA;
   logic [2:0]  AWPROT = 3'h5;
   logic [3:0]  AWQOS = 4'hC;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [63:0] WDATA = '0;
   logic [7:0]  WSTRB = '0;
   logic        WLAST = 1'b0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [76:0] DATAo;
   logic        VALIDo;
   logic        READYo = 1'b1;
   logic        LEN_ERR;

   int n_cmp = 0;
   int n_bad = 0;

   aw_w_packer u_dut (
      .CLK     (CLK),
      .RESETn  (RESETn),
      .AWADDR  (AWADDR),
      .AWID    (AWID),
      .AWLEN   (AWLEN),
      .AWSIZE  (AWSIZE),
      .AWBURST (AWBURST),
      .AWCACHE (AWCACHE),
      .AWPROT  (AWPROT),
      .AWQOS   (AWQOS),
      .AWVALID (AWVALID),
      .AWREADY (AWREADY),
      .WDATA   (WDATA),
      .WSTRB   (WSTRB),
      .WLAST   (WLAST),
      .WVALID  (WVALID),
      .WREADY  (WREADY),
      .DATAo   (DATAo),
      .VALIDo  (VALIDo),
      .READYo  (READYo),
      .LEN_ERR (LEN_ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        awv;
      logic [35:0] addr;
      logic [7:0]  len;
      logic [3:0]  id;
      logic        wv;
      logic [63:0] wd;
      logic [7:0]  ws;
      logic        wl;
      logic        rdy;
      logic        e_awr;
      logic        e_wr;
      logic        e_v;
      logic [76:0] e_d;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic awv, logic [35:0] addr, logic [7:0] len, logic [3:0] id,
                               logic wv, logic [63:0] wd, logic [7:0] ws, logic wl, logic rdy,
                               logic e_awr, logic e_wr, logic e_v, logic [76:0] e_d);
      vec_t v;
      v.awv = awv; v.addr = addr; v.len = len; v.id = id;
      v.wv = wv; v.wd = wd; v.ws = ws; v.wl = wl; v.rdy = rdy;
      v.e_awr = e_awr; v.e_wr = e_wr; v.e_v = e_v; v.e_d = e_d;
      return v;
   endfunction

   function automatic logic [63:0] dw(int k);
      return {32'hDA7A_5EED, 32'(k) * 32'h1357_9BDF};
   endfunction

   function automatic logic [76:0] cmd(logic [35:0] addr, logic [7:0] len, logic [3:0] id);
      return {len, addr, id, 3'd3, 2'd1, 4'hA, 3'h5, 4'hC, 13'd0};
   endfunction

   function automatic logic [76:0] db(logic [63:0] wd, logic [7:0] ws, logic last);
      return {4'd0, wd, ws, last};
   endfunction

   task automatic chk(string name, logic [76:0] act, logic [76:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(vec_t v);
      AWVALID = v.awv; AWADDR = v.addr; AWLEN = v.len; AWID = v.id;
      WVALID = v.wv; WDATA = v.wd; WSTRB = v.ws; WLAST = v.wl; READYo = v.rdy;
   endtask

   localparam logic [35:0] A = 36'h1_2345_6780;
   localparam logic [35:0] B = 36'h0_0000_1000;
   localparam logic [35:0] C = 36'h8_0000_2040;
   localparam logic [35:0] F = 36'h0_ABCD_0100;
   localparam logic [35:0] I = 36'h0_5555_0000;
   localparam logic [35:0] J = 36'hF_0000_0008;
   localparam logic [35:0] M = 36'h3_0303_0300;
   localparam logic [35:0] N = 36'h6_0000_0FF0;

   initial begin
      // Reset release, then the main stream scenarios, one row per cycle.
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, A, 3, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(0), 8'hFF, 0, 1, 0, 1, 1, cmd(A, 3, 5)));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(1), 8'h0F, 0, 1, 0, 1, 1, db(dw(0), 8'hFF, 0)));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(2), 8'hF0, 0, 1, 0, 1, 1, db(dw(1), 8'h0F, 0)));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(3), 8'hA5, 1, 1, 0, 1, 1, db(dw(2), 8'hF0, 0)));
      vecs.push_back(mk(1, B, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1, db(dw(3), 8'hA5, 1)));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(4), 8'hFF, 1, 1, 0, 1, 1, cmd(B, 0, 1)));
      vecs.push_back(mk(1, C, 0, 2, 0, 0, 0, 0, 1, 1, 0, 1, db(dw(4), 8'hFF, 1)));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(5), 8'h3C, 1, 1, 0, 1, 1, cmd(C, 0, 2)));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, db(dw(5), 8'h3C, 1)));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, F, 2, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(6), 8'hFF, 0, 1, 0, 1, 1, cmd(F, 2, 7)));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(7), 8'h81, 0, 0, 0, 0, 1, db(dw(6), 8'hFF, 0)));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(7), 8'h81, 0, 0, 0, 0, 1, db(dw(6), 8'hFF, 0)));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(7), 8'h81, 0, 0, 0, 0, 1, db(dw(6), 8'hFF, 0)));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(7), 8'h81, 0, 1, 0, 1, 1, db(dw(6), 8'hFF, 0)));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(8), 8'hFF, 1, 1, 0, 1, 1, db(dw(7), 8'h81, 0)));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, db(dw(8), 8'hFF, 1)));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(9), 8'hFF, 1, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, I, 0, 3, 1, dw(9), 8'hFF, 1, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(9), 8'hFF, 1, 1, 0, 1, 1, cmd(I, 0, 3)));
      vecs.push_back(mk(1, J, 1, 9, 0, 0, 0, 0, 0, 0, 0, 1, db(dw(9), 8'hFF, 1)));
      vecs.push_back(mk(1, J, 1, 9, 0, 0, 0, 0, 1, 1, 0, 1, db(dw(9), 8'hFF, 1)));
      vecs.push_back(mk(0, 0, 0, 0, 1, dw(10), 8'hFF, 1, 1, 0, 1, 1, cmd(J, 1, 9)));

      // Reset state while RESETn is low.
      @(negedge CLK);
      #1;
      chk("reset VALIDo", 77'(VALIDo), 77'(0));
      chk("reset DATAo", DATAo, 77'd0);
      chk("reset AWREADY", 77'(AWREADY), 77'(0));
      chk("reset WREADY", 77'(WREADY), 77'(0));
      chk("reset LEN_ERR", 77'(LEN_ERR), 77'(0));
      @(negedge CLK);
      RESETn = 1'b1;

      foreach (vecs[i]) begin
         apply(vecs[i]);
         #1;
         chk($sformatf("row%0d AWREADY", i), 77'(AWREADY), 77'(vecs[i].e_awr));
         chk($sformatf("row%0d WREADY", i), 77'(WREADY), 77'(vecs[i].e_wr));
         chk($sformatf("row%0d VALIDo", i), 77'(VALIDo), 77'(vecs[i].e_v));
         chk($sformatf("row%0d LEN_ERR", i), 77'(LEN_ERR), 77'(0));
         if (vecs[i].e_v) begin
            chk($sformatf("row%0d DATAo", i), DATAo, vecs[i].e_d);
         end
         @(negedge CLK);
      end

      // Length mismatch: AWLEN=1 burst whose first W beat carries WLAST=1.
`ifdef AW_W_PACKER_LEN_CHECK_EN
      WVALID = 1'b1; WDATA = dw(13); WSTRB = 8'hFF; WLAST = 1'b1;
      #1;
      chk("len beat0 DATAo", DATAo, db(dw(10), 8'hFF, 0));
      chk("len beat0 WREADY", 77'(WREADY), 77'(1));
      chk("len beat0 LEN_ERR", 77'(LEN_ERR), 77'(1));
      @(negedge CLK);
      WVALID = 1'b0;
      #1;
      chk("len beat1 DATAo", DATAo, db(dw(13), 8'hFF, 1));
      chk("len beat1 AWREADY", 77'(AWREADY), 77'(1));
      chk("len sticky LEN_ERR", 77'(LEN_ERR), 77'(1));
`else
      WVALID = 1'b0;
      #1;
      chk("len beat0 DATAo", DATAo, db(dw(10), 8'hFF, 1));
      chk("len beat0 VALIDo", 77'(VALIDo), 77'(1));
      chk("len back to cmd AWREADY", 77'(AWREADY), 77'(1));
      chk("len back to cmd WREADY", 77'(WREADY), 77'(0));
      chk("len LEN_ERR", 77'(LEN_ERR), 77'(0));
`endif
      @(negedge CLK);
      #1;
      chk("len drained VALIDo", 77'(VALIDo), 77'(0));

      // Reset asserted mid-burst drops the in-flight beat immediately.
      @(negedge CLK);
      AWVALID = 1'b1; AWADDR = M; AWLEN = 8'd3; AWID = 4'd4; READYo = 1'b1;
      #1;
      chk("mid AWREADY", 77'(AWREADY), 77'(1));
      @(negedge CLK);
      AWVALID = 1'b0; WVALID = 1'b1; WDATA = dw(11); WSTRB = 8'hFF; WLAST = 1'b0;
      #1;
      chk("mid cmd DATAo", DATAo, cmd(M, 3, 4));
      @(negedge CLK);
      WVALID = 1'b0;
      #1;
      chk("mid data DATAo", DATAo, db(dw(11), 8'hFF, 0));
      #2 RESETn = 1'b0;
      #1;
      chk("mid rst VALIDo", 77'(VALIDo), 77'(0));
      chk("mid rst DATAo", DATAo, 77'd0);
      chk("mid rst WREADY", 77'(WREADY), 77'(0));
      chk("mid rst AWREADY", 77'(AWREADY), 77'(0));
      chk("mid rst LEN_ERR", 77'(LEN_ERR), 77'(0));
      @(negedge CLK);
      RESETn = 1'b1;
      #1;
      chk("rerel AWREADY first", 77'(AWREADY), 77'(0));
      @(negedge CLK);
      #1;
      chk("rerel AWREADY second", 77'(AWREADY), 77'(1));
      chk("rerel WREADY", 77'(WREADY), 77'(0));
      AWVALID = 1'b1; AWADDR = N; AWLEN = 8'd0; AWID = 4'd6;
      @(negedge CLK);
      AWVALID = 1'b0; WVALID = 1'b1; WDATA = dw(12); WSTRB = 8'h5A; WLAST = 1'b1;
      #1;
      chk("post rst cmd DATAo", DATAo, cmd(N, 0, 6));
      chk("post rst WREADY", 77'(WREADY), 77'(1));
      @(negedge CLK);
      WVALID = 1'b0;
      #1;
      chk("post rst data DATAo", DATAo, db(dw(12), 8'h5A, 1));
      chk("post rst VALIDo", 77'(VALIDo), 77'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
